// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper family.
package tt_sweep_pkg;

   // Widest combinational module the sweepers are expected to handle.
   localparam int TT_MAX_N = 8;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } tt_state_e;

   // Number of truth-table rows for an n-input function.
   function automatic int rows(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control, stimulus and result bundle between the verification flow and a sweeper.
interface truth_table_sweeper_if
   import tt_sweep_pkg::*;
#(
   parameter int N = 3
);
   localparam int ROWS = rows(N);

   logic            start;
   logic            abort;
   logic [ROWS-1:0] expected;
   logic            dut_out;
   logic [N-1:0]    dut_inp;
   logic            busy;
   logic            done;
   logic            pass;
   logic [ROWS-1:0] captured;
   logic [N:0]      err_count;
   logic [N-1:0]    first_err_idx;

   // The flow side: issues commands, supplies the expected table and the DUT response.
   modport master (
      output start, abort, expected, dut_out,
      input  dut_inp, busy, done, pass, captured, err_count, first_err_idx
   );

   // The sweeper side.
   modport slave (
      input  start, abort, expected, dut_out,
      output dut_inp, busy, done, pass, captured, err_count, first_err_idx
   );

endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter that flags when a held input vector has settled long enough.
module tt_settle_timer #(
   parameter int SETTLE = 2,
   parameter int W      = $clog2(SETTLE) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;

   // Load wins over decrement; the count parks at zero until reloaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= value;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input combination onto a combinational DUT, captures its output
// and scores the captured truth table against a latched expected table.
module truth_table_sweeper
   import tt_sweep_pkg::*;
#(
   parameter int N      = 3,
   parameter int SETTLE = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   truth_table_sweeper_if.slave bus
);

   localparam int ROWS = rows(N);
   localparam int TW   = $clog2(SETTLE) + 1;
   localparam logic [N:0]    LAST_IDX   = (N+1)'(ROWS - 1);
   localparam logic [TW-1:0] SETTLE_LD  = TW'(SETTLE - 1);

   tt_state_e       state_q, state_d;
   logic [N:0]      idx_q;
   logic [N:0]      idx_next;
   logic [ROWS-1:0] exp_q;
   logic [ROWS-1:0] captured_q;
   logic [N:0]      err_q;
   logic [N-1:0]    first_q;
   logic            pass_q;
   logic [N-1:0]    inp_q;

   logic accept;
   logic sample_en;
   logic quit;
   logic timer_load;
   logic timer_dec;
   logic timer_zero;
   logic mismatch;
   logic last_row;

   assign idx_next = idx_q + 1'b1;
   assign last_row = (idx_q == LAST_IDX);
   assign mismatch = (bus.dut_out != exp_q[idx_q[N-1:0]]);

   tt_settle_timer #(
      .SETTLE (SETTLE),
      .W      (TW)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (timer_load),
      .value (SETTLE_LD),
      .dec   (timer_dec),
      .zero  (timer_zero)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= tt_sweep_pkg::IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode plus the strobes that steer the timer and datapath.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      sample_en  = 1'b0;
      quit       = 1'b0;
      timer_load = 1'b0;
      timer_dec  = 1'b0;
      case (state_q)
         tt_sweep_pkg::IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               timer_load = 1'b1;
               state_d    = tt_sweep_pkg::SETTLE;
            end
         end
         tt_sweep_pkg::SETTLE: begin
            if (bus.abort) begin
               quit    = 1'b1;
               state_d = tt_sweep_pkg::IDLE;
            end else if (timer_zero) begin
               state_d = tt_sweep_pkg::SAMPLE;
            end else begin
               timer_dec = 1'b1;
            end
         end
         tt_sweep_pkg::SAMPLE: begin
            sample_en = 1'b1;
            if (bus.abort) begin
               quit    = 1'b1;
               state_d = tt_sweep_pkg::IDLE;
            end else if (last_row) begin
               state_d = tt_sweep_pkg::DONE;
            end else begin
               timer_load = 1'b1;
               state_d    = tt_sweep_pkg::SETTLE;
            end
         end
         tt_sweep_pkg::DONE: begin
            state_d = tt_sweep_pkg::IDLE;
         end
         default: begin
            state_d = tt_sweep_pkg::IDLE;
         end
      endcase
   end

   // Sweep datapath: row pointer, stimulus, capture and mismatch scoring.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q      <= '0;
         exp_q      <= '0;
         captured_q <= '0;
         err_q      <= '0;
         first_q    <= '0;
         pass_q     <= 1'b0;
         inp_q      <= '0;
      end else begin
         if (accept) begin
            exp_q      <= bus.expected;
            captured_q <= '0;
            err_q      <= '0;
            first_q    <= '0;
            pass_q     <= 1'b0;
            idx_q      <= '0;
            inp_q      <= '0;
         end
         if (sample_en) begin
            captured_q[idx_q[N-1:0]] <= bus.dut_out;
            if (mismatch) begin
               err_q <= err_q + 1'b1;
               if (err_q == '0) begin
                  first_q <= idx_q[N-1:0];
               end
            end
            if (!bus.abort) begin
               if (last_row) begin
                  pass_q <= (err_q == '0) && !mismatch;
               end else begin
                  idx_q <= idx_next;
                  inp_q <= idx_next[N-1:0];
               end
            end
         end
         if (quit) begin
            inp_q <= '0;
         end
      end
   end

   assign bus.dut_inp       = inp_q;
   assign bus.busy          = (state_q == tt_sweep_pkg::SETTLE) || (state_q == tt_sweep_pkg::SAMPLE);
   assign bus.done          = (state_q == tt_sweep_pkg::DONE);
   assign bus.pass          = pass_q;
   assign bus.captured      = captured_q;
   assign bus.err_count     = err_q;
   assign bus.first_err_idx = first_q;

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Upstream stimulus/capture stage for the N-input combinational truth-table modules the synthesizer emits, such as the 3-input constant-1 function.
- Walks every input combination 0..2^N-1 onto the DUT inputs and waits a programmable settle time.
- Samples the DUT output, assembles the captured truth table and compares it against an expected table.
- Reports pass/fail, mismatch count and first failing row to the netlist-verification flow.

Parameters:
- N, 3, number of DUT inputs (1..8).
- SETTLE, 2, cycles each input vector is held before sampling (>=1).
- ROWS, 2**N, derived localparam; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a sweep when sampled high in IDLE.
- abort  in  1  terminates a sweep in progress.
- expected  in  ROWS  expected table; bit i = output for input vector i.
- dut_out  in  1  DUT output, sampled.
- dut_inp  out  N  DUT input vector; bit N-1 drives inp1 (MSB), bit 0 drives inpN.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse on completion.
- pass  out  1  captured == expected; valid when done, held until next start.
- captured  out  ROWS  observed table, bit i = dut_out for row i.
- err_count  out  N+1  number of mismatching rows (0..ROWS).
- first_err_idx  out  N  lowest mismatching row; 0 when err_count==0.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; dut_inp=0; busy=0; done=0; pass=0; captured=0; err_count=0; first_err_idx=0; internal idx and timer cleared. Reset mid-sweep discards all progress.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1: latch expected into exp_q; clear captured, err_count, first_err_idx and pass; set idx=0, dut_inp=0, timer=SETTLE-1; go to SETTLE.
- SETTLE:
  - Hold dut_inp=idx.
  - timer==0 -> SAMPLE; else decrement timer.
- SAMPLE (one cycle):
  - captured[idx]<=dut_out.
  - If dut_out!=exp_q[idx]: err_count++, and if this is the first error, first_err_idx<=idx.
  - If idx==ROWS-1 -> DONE.
  - Else idx++, dut_inp<=idx+1, timer=SETTLE-1 -> SETTLE.
  - idx is N+1 bits internally so no wrap occurs at ROWS-1.
- DONE (one cycle):
  - done=1; pass<=(err_count==0); busy=0 -> IDLE.
  - pass is registered so it is valid in the same cycle as done. Implementation computes it from the final compare result.
- Timing: each row occupies SETTLE+1 cycles. With start accepted at edge 0, done is high during cycle ROWS*(SETTLE+1)+1. For N=3 and SETTLE=2, done is asserted 25 cycles after the start edge.
- busy = state in {SETTLE, SAMPLE}.
- start while busy or in DONE: ignored, with no restart.
- start and abort high together in IDLE: start wins; abort has no effect in IDLE.
- abort in SETTLE or SAMPLE:
  - Next state IDLE, dut_inp=0, no done pulse.
  - captured, err_count and first_err_idx keep partial values; pass stays 0.
  - A SAMPLE cycle coinciding with abort still records its row.
- expected changes mid-sweep have no effect because exp_q is latched.
- dut_out is assumed to come from a combinational DUT; no synchronizer is applied.

Decomposition:
- Package tt_sweep_pkg holds:
  - state enum tt_state_e {IDLE, SETTLE, SAMPLE, DONE};
  - function rows(n)=1<<n;
  - constant TT_MAX_N=8.
- One sub-module: tt_settle_timer (load, value, zero flag, width $clog2(SETTLE)+1). It is reused by future multi-output sweepers.
- Compare and accumulate logic stays inline.

Test Plan:
1. N=3, SETTLE=2, DUT = constant-1 model, expected=8'hFF, pulse start -> dut_inp steps 0..7 every 3 cycles; done at cycle 25; pass=1, captured=8'hFF, err_count=0, first_err_idx=0.
2. DUT = 3-input XOR (table 8'h96), expected=8'hFF -> captured=8'h96, err_count=4, first_err_idx=0, pass=0.
3. Pulse start again at cycle 10 while busy -> sweep unaffected, done exactly once at cycle 25, no restart.
4. Assert abort during SETTLE of row 5 (constant-1 DUT) -> IDLE next cycle, dut_inp=0, no done, captured=8'h1F, busy=0; a following start runs a full clean sweep.
5. Drive rst_n low asynchronously mid-sweep (between clock edges, row 3) -> all outputs 0 immediately. Release, then start -> full sweep with correct results.
6. N=1, SETTLE=1, DUT=inverter, expected=2'b01 -> row period 2 cycles, done at cycle 5, captured=2'b01, pass=1.
